// File: rtl/tt_um_emern_spi_pkg.sv
// Shared definitions for the SPI scene register file.
//   - register addresses and payload lengths (in bytes)
//   - SPI slave FSM state type
//   - field widths and bit offsets inside the 48-bit polygon word
//     {color[5:0], v0x[6:0], v0y[5:0], v1x[6:0], v1y[5:0], v2x[6:0], v2y[5:0], depth[2:0]}
package tt_um_emern_spi_pkg;

  localparam logic [2:0] ADDR_BG    = 3'd0;
  localparam logic [2:0] ADDR_EN    = 3'd1;
  localparam logic [2:0] ADDR_POLY0 = 3'd2;
  localparam logic [2:0] ADDR_POLY1 = 3'd3;

  localparam logic [2:0] LEN_BYTE = 3'd1;
  localparam logic [2:0] LEN_POLY = 3'd6;

  localparam int POLY_W = 48;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_DATA = 2'd2,
    ST_DONE = 2'd3
  } spi_state_t;

  localparam int COLOR_W = 6;
  localparam int X_W     = 7;
  localparam int Y_W     = 6;
  localparam int DEPTH_W = 3;

  localparam int COLOR_OFF = 42;
  localparam int V0X_OFF   = 35;
  localparam int V0Y_OFF   = 29;
  localparam int V1X_OFF   = 22;
  localparam int V1Y_OFF   = 16;
  localparam int V2X_OFF   = 9;
  localparam int V2Y_OFF   = 3;
  localparam int DEPTH_OFF = 0;

  // Reserved addresses behave like 1-byte registers: the host may clock one
  // byte, which is ignored on write and reads back as zero.
  function automatic logic [2:0] payload_len(input logic [2:0] addr);
    case (addr)
      ADDR_POLY0, ADDR_POLY1: payload_len = LEN_POLY;
      default:                payload_len = LEN_BYTE;
    endcase
  endfunction

endpackage

// File: rtl/tt_um_emern_spi_sync.sv
// Multi-flop synchronizer for one asynchronous input, with edge detection
// taken from the last two synchronized samples.
//   clk, rst_n : system clock, asynchronous active-low reset
//   d          : asynchronous input
//   q          : synchronized level
//   rise, fall : one-cycle pulses on synchronized 0->1 / 1->0 transitions
module tt_um_emern_spi_sync #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain_q, chain_d;
  logic              prev_q, prev_d;

  always_comb begin
    chain_d = {chain_q[STAGES-2:0], d};
    prev_d  = chain_q[STAGES-1];
  end

  // Reset to the line's idle level so reset release does not look like an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain_q <= {STAGES{RESET_VAL}};
      prev_q  <= RESET_VAL;
    end else begin
      chain_q <= chain_d;
      prev_q  <= prev_d;
    end
  end

  assign q    = chain_q[STAGES-1];
  assign rise = chain_q[STAGES-1] & ~prev_q;
  assign fall = ~chain_q[STAGES-1] & prev_q;

endmodule

// File: rtl/tt_um_emern_spi_regfile.sv
// SPI slave (mode 0, MSB first) with a double-buffered scene register file.
// The host writes shadow registers at any time; shadows are copied to the
// active output registers only while en_load is high, so the pixel core never
// sees a partially updated scene.
//   clk, rst_n        : pixel clock, asynchronous active-low reset
//   cs_in/sck_in/mosi_in/miso_out : SPI slave pins (cs active low)
//   en_load           : commit window (screen blanked)
//   bg_color_out      : background colour
//   poly_color_out, v*_x_out, v*_y_out, poly_depth_out : {poly1, poly0} fields
//   poly_enable_out   : bit n enables polygon n
//
// Transaction: command byte {R/nW, 4'bx, addr[2:0]} then payload bytes.
// Handshake note: there is no valid/ready pair here; a shadow write is accepted
// exactly when the last payload bit is sampled, and the commit is a level
// condition (en_load & pending) acted on in the same clock.
module tt_um_emern_spi_regfile
  import tt_um_emern_spi_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cs_in,
  input  logic        sck_in,
  input  logic        mosi_in,
  output logic        miso_out,
  input  logic        en_load,
  output logic [5:0]  bg_color_out,
  output logic [11:0] poly_color_out,
  output logic [13:0] v0_x_out,
  output logic [13:0] v1_x_out,
  output logic [13:0] v2_x_out,
  output logic [11:0] v0_y_out,
  output logic [11:0] v1_y_out,
  output logic [11:0] v2_y_out,
  output logic [5:0]  poly_depth_out,
  output logic [1:0]  poly_enable_out
);

  logic cs_level_unused, cs_rise, cs_fall;
  logic sck_level_unused, sck_rise, sck_fall;
  logic mosi_s, mosi_rise_unused, mosi_fall_unused;

  tt_um_emern_spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
    .clk(clk), .rst_n(rst_n), .d(cs_in),
    .q(cs_level_unused), .rise(cs_rise), .fall(cs_fall)
  );

  tt_um_emern_spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sck (
    .clk(clk), .rst_n(rst_n), .d(sck_in),
    .q(sck_level_unused), .rise(sck_rise), .fall(sck_fall)
  );

  tt_um_emern_spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .rst_n(rst_n), .d(mosi_in),
    .q(mosi_s), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
  );

  spi_state_t        state_q, state_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [2:0]        byte_cnt_q, byte_cnt_d;
  logic [2:0]        addr_q, addr_d;
  logic              rw_q, rw_d;
  logic [POLY_W-1:0] stage_q, stage_d;
  logic [POLY_W-1:0] tx_q, tx_d;
  logic              miso_q, miso_d;
  logic              pending_q, pending_d;

  logic [5:0]        bg_sh_q, bg_sh_d;
  logic [1:0]        en_sh_q, en_sh_d;
  logic [POLY_W-1:0] p0_sh_q, p0_sh_d;
  logic [POLY_W-1:0] p1_sh_q, p1_sh_d;

  logic [5:0]        bg_q, bg_d;
  logic [1:0]        en_q, en_d;
  logic [POLY_W-1:0] p0_q, p0_d;
  logic [POLY_W-1:0] p1_q, p1_d;

  logic [2:0]        next_addr;
  logic [POLY_W-1:0] tx_load;
  logic              wr_done;

  // Address after the final command bit; needed in the same cycle to preload
  // the read shift register.
  assign next_addr = {addr_q[1:0], mosi_s};

  // Read data is left-aligned so bit 47 is always the next bit on the wire.
  always_comb begin
    tx_load = '0;
    case (next_addr)
      ADDR_BG:    tx_load = {2'b00, bg_sh_q, 40'd0};
      ADDR_EN:    tx_load = {6'd0, en_sh_q, 40'd0};
      ADDR_POLY0: tx_load = p0_sh_q;
      ADDR_POLY1: tx_load = p1_sh_q;
      default:    tx_load = '0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    byte_cnt_d = byte_cnt_q;
    addr_d     = addr_q;
    rw_d       = rw_q;
    stage_d    = stage_q;
    tx_d       = tx_q;
    miso_d     = miso_q;
    wr_done    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        miso_d = 1'b0;
        if (cs_fall) begin
          state_d   = ST_CMD;
          bit_cnt_d = 3'd0;
        end
      end
      ST_CMD: begin
        miso_d = 1'b0;
        if (sck_rise) begin
          if (bit_cnt_q == 3'd0) rw_d = mosi_s;
          addr_d    = next_addr;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            state_d    = ST_DATA;
            byte_cnt_d = 3'd0;
            tx_d       = tx_load;
          end
        end
      end
      ST_DATA: begin
        // The first fall seen here is the one ending the command byte.
        if (sck_fall) begin
          miso_d = rw_q & tx_q[POLY_W-1];
          tx_d   = {tx_q[POLY_W-2:0], 1'b0};
        end
        if (sck_rise) begin
          stage_d   = {stage_q[POLY_W-2:0], mosi_s};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            byte_cnt_d = byte_cnt_q + 3'd1;
            if (byte_cnt_q == payload_len(addr_q) - 3'd1) begin
              state_d = ST_DONE;
              miso_d  = 1'b0;
              wr_done = ~rw_q & ~addr_q[2];
            end
          end
        end
      end
      ST_DONE: begin
        miso_d = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
        miso_d  = 1'b0;
      end
    endcase

    if (cs_rise) begin
      state_d = ST_IDLE;
      miso_d  = 1'b0;
    end
  end

  // Shadow writes, commit and pending. The commit copies the registered
  // shadows, so a write landing in the commit cycle is not included and keeps
  // pending set for the next window.
  always_comb begin
    bg_sh_d   = bg_sh_q;
    en_sh_d   = en_sh_q;
    p0_sh_d   = p0_sh_q;
    p1_sh_d   = p1_sh_q;
    bg_d      = bg_q;
    en_d      = en_q;
    p0_d      = p0_q;
    p1_d      = p1_q;
    pending_d = pending_q;

    if (en_load && pending_q) begin
      bg_d      = bg_sh_q;
      en_d      = en_sh_q;
      p0_d      = p0_sh_q;
      p1_d      = p1_sh_q;
      pending_d = 1'b0;
    end

    if (wr_done) begin
      pending_d = 1'b1;
      case (addr_q)
        ADDR_BG:    bg_sh_d = stage_d[5:0];
        ADDR_EN:    en_sh_d = stage_d[1:0];
        ADDR_POLY0: p0_sh_d = stage_d;
        ADDR_POLY1: p1_sh_d = stage_d;
        default:    pending_d = pending_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= '0;
      byte_cnt_q <= '0;
      addr_q     <= '0;
      rw_q       <= 1'b0;
      stage_q    <= '0;
      tx_q       <= '0;
      miso_q     <= 1'b0;
      pending_q  <= 1'b0;
      bg_sh_q    <= '0;
      en_sh_q    <= '0;
      p0_sh_q    <= '0;
      p1_sh_q    <= '0;
      bg_q       <= '0;
      en_q       <= '0;
      p0_q       <= '0;
      p1_q       <= '0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      addr_q     <= addr_d;
      rw_q       <= rw_d;
      stage_q    <= stage_d;
      tx_q       <= tx_d;
      miso_q     <= miso_d;
      pending_q  <= pending_d;
      bg_sh_q    <= bg_sh_d;
      en_sh_q    <= en_sh_d;
      p0_sh_q    <= p0_sh_d;
      p1_sh_q    <= p1_sh_d;
      bg_q       <= bg_d;
      en_q       <= en_d;
      p0_q       <= p0_d;
      p1_q       <= p1_d;
    end
  end

  assign miso_out        = miso_q;
  assign bg_color_out    = bg_q;
  assign poly_enable_out = en_q;
  assign poly_color_out  = {p1_q[COLOR_OFF +: COLOR_W], p0_q[COLOR_OFF +: COLOR_W]};
  assign v0_x_out        = {p1_q[V0X_OFF +: X_W], p0_q[V0X_OFF +: X_W]};
  assign v1_x_out        = {p1_q[V1X_OFF +: X_W], p0_q[V1X_OFF +: X_W]};
  assign v2_x_out        = {p1_q[V2X_OFF +: X_W], p0_q[V2X_OFF +: X_W]};
  assign v0_y_out        = {p1_q[V0Y_OFF +: Y_W], p0_q[V0Y_OFF +: Y_W]};
  assign v1_y_out        = {p1_q[V1Y_OFF +: Y_W], p0_q[V1Y_OFF +: Y_W]};
  assign v2_y_out        = {p1_q[V2Y_OFF +: Y_W], p0_q[V2Y_OFF +: Y_W]};
  assign poly_depth_out  = {p1_q[DEPTH_OFF +: DEPTH_W], p0_q[DEPTH_OFF +: DEPTH_W]};

endmodule
